// File: rtl/acc_cpu_sequencer.sv
// rtl/acc_cpu_sequencer.sv - fetch/decode/execute sequencer with PC, IR and loader arbitration
`timescale 1ns/1ps
module acc_cpu_sequencer #(
  parameter int               ADDR_W       = 8,
  parameter int               OPC_W        = 5,
  parameter logic [OPC_W-1:0] HALT_OPC     = 5'h1F,
  parameter int               EXEC_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we_req,
  input  logic [ADDR_W-1:0] prog_addr,
  output logic              prog_ack,
  output logic              ram_en,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  output logic              stage_ld,
  output logic [OPC_W-1:0]  opcode,
  output logic [2:0]        addr_mode,
  output logic [7:0]        operand,
  output logic              exec_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;

  // State register and datapath flops; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next state, PC/IR updates and EXEC timeout; the counter is zero whenever not in EXEC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        // a pending loader write takes the cycle, so start is dropped
        if (!prog_we_req && start) begin
          pc_d    = '0;
          fault_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = ram_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = (OPC_W'(ram_rdata[15:11]) == HALT_OPC) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (exec_done) begin
          if (branch_taken) pc_d = ADDR_W'(ir_q[7:0]);
          cnt_d   = '0;
          state_d = S_FETCH;
        end else if (cnt_d == CNT_W'(EXEC_TIMEOUT)) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and RAM port mux; all suppressed during the reset cycle
  always_comb begin
    prog_ack     = 1'b0;
    ram_en       = 1'b0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    ram_addr     = '0;
    stage_ld     = 1'b0;
    exec_valid   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          prog_ack     = prog_we_req;
          ram_write_en = prog_we_req;
          ram_en       = prog_we_req;
          ram_addr     = prog_we_req ? prog_addr : '0;
        end
        S_FETCH: begin
          ram_en      = 1'b1;
          ram_read_en = 1'b1;
          ram_addr    = pc_q;
        end
        S_DECODE: stage_ld = 1'b1;
        S_EXEC:   exec_valid = (cnt_q == '0);
        default: ;
      endcase
    end
  end

  assign opcode    = OPC_W'(ir_q[15:11]);
  assign addr_mode = ir_q[10:8];
  assign operand   = ir_q[7:0];
  assign pc        = pc_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// tb/tb_acc_cpu_sequencer.sv - scoreboard bench with program-level reference model
`timescale 1ns/1ps
module tb_acc_cpu_sequencer;

  localparam int EXEC_TIMEOUT = 16;
  localparam int MAXI         = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        prog_we_req = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic        prog_ack;
  logic        ram_en, ram_read_en, ram_write_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_rdata = '0;
  logic        stage_ld;
  logic [4:0]  opcode;
  logic [2:0]  addr_mode;
  logic [7:0]  operand;
  logic        exec_valid;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  pc;
  logic        busy, halted, fault;

  always #5 clk = ~clk;

  acc_cpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_we_req(prog_we_req), .prog_addr(prog_addr), .prog_ack(prog_ack),
    .ram_en(ram_en), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .stage_ld(stage_ld),
    .opcode(opcode), .addr_mode(addr_mode), .operand(operand),
    .exec_valid(exec_valid), .exec_done(exec_done), .branch_taken(branch_taken),
    .pc(pc), .busy(busy), .halted(halted), .fault(fault)
  );

  logic [15:0] ram [256];
  logic [15:0] load_data = '0;
  logic [15:0] model_mem [256];
  int          lat_tab [MAXI];
  bit          br_tab [MAXI];
  int          resp_idx = 0;

  logic [7:0]  exp_fetch [$];
  logic [23:0] exp_exec [$];
  logic [7:0]  exp_ack [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction RAM: writes only through the DUT strobes, 1-cycle sync read
  always @(posedge clk) begin
    if (ram_en && ram_write_en) ram[ram_addr] <= load_data;
    if (ram_en && ram_read_en) ram_rdata <= ram[ram_addr];
  end

  // datapath stand-in: finishes each instruction after lat_tab cycles (0 = never)
  int r_l, r_k;
  bit r_b;
  always begin
    @(negedge clk);
    if (exec_valid && !rst) begin
      r_l = lat_tab[resp_idx];
      r_b = br_tab[resp_idx];
      if (resp_idx < MAXI - 1) resp_idx++;
      r_k = 1;
      forever begin
        exec_done    = (r_l == r_k);
        branch_taken = (r_l == r_k) ? r_b : 1'($urandom_range(0, 1));
        @(negedge clk);
        if (r_l == r_k || r_k == EXEC_TIMEOUT) break;
        r_k++;
      end
      exec_done    = 1'b0;
      branch_taken = 1'b0;
    end
  end

  // monitor: pops expected fetches, issued instructions and loader grants
  logic prev_read = 1'b0;
  logic [23:0] exp_item;
  always @(negedge clk) begin
    if (rst) begin
      prev_read = 1'b0;
    end else begin
      if (ram_read_en) begin
        if (exp_fetch.size() == 0) chk("fetch_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
        else chk("fetch_addr", 32'(ram_addr), 32'(exp_fetch.pop_front()));
        chk("fetch_strobes", 32'({ram_en, ram_write_en}), 32'(2'b10));
      end
      if (stage_ld) chk("stage_ld_after_fetch", 32'(prev_read), 32'd1);
      if (exec_valid) begin
        if (exp_exec.size() == 0) chk("exec_unexpected", 32'({pc, opcode, addr_mode, operand}), 32'hFFFF_FFFF);
        else begin
          exp_item = exp_exec.pop_front();
          chk("exec_item", 32'({pc, opcode, addr_mode, operand}), 32'(exp_item));
        end
      end
      if (prog_ack) begin
        if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
        else chk("ack_addr", 32'(ram_addr), 32'(exp_ack.pop_front()));
        chk("ack_write", 32'({ram_en, ram_write_en, busy}), 32'(3'b110));
      end else if (prog_we_req) begin
        chk("req_blocked", 32'({busy, ram_write_en}), 32'(2'b10));
      end
      prev_read = ram_read_en;
    end
  end

  // program-level reference: walks the program, pushing expected fetches and issues
  task automatic model(output logic [7:0] fpc, output bit ffault);
    logic [7:0]  p;
    logic [15:0] w;
    int          n;
    p = 8'd0;
    n = 0;
    ffault = 1'b0;
    forever begin
      exp_fetch.push_back(p);
      w = model_mem[p];
      p = p + 8'd1;
      if (w[15:11] == 5'h1F) break;
      exp_exec.push_back({p, w});
      if (lat_tab[n] == 0) begin
        ffault = 1'b1;
        break;
      end
      if (br_tab[n]) p = w[7:0];
      n++;
    end
    fpc = p;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    for (int i = 0; i < MAXI; i++) begin
      lat_tab[i] = (i == MAXI - 1) ? 0 : 1;
      br_tab[i]  = 1'b0;
    end
  endtask

  task automatic load_prog();
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      prog_we_req = 1'b1;
      prog_addr   = 8'(a);
      load_data   = model_mem[a];
      exp_ack.push_back(8'(a));
      @(negedge clk);
    end
    @(posedge clk); #1;
    prog_we_req = 1'b0;
  endtask

  task automatic run_prog(output int cyc);
    logic [7:0] fpc;
    bit         ffault;
    logic [7:0] wa;
    model(fpc, ffault);
    resp_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wa = 8'($urandom_range(0, 255));
    prog_we_req = 1'b1;
    prog_addr   = wa;
    load_data   = model_mem[wa];
    exp_ack.push_back(wa);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("run_started", 32'({busy, fault}), 32'(2'b10));
      if (halted) break;
      if (busy && $urandom_range(0, 9) == 0) start = 1'b1;
    end while (cyc < 5000);
    chk("halt_reached", 32'(halted), 32'd1);
    chk("final_fault", 32'(fault), 32'(ffault));
    chk("final_pc", 32'(pc), 32'(fpc));
    chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
    chk("exec_queue_drained", 32'(exp_exec.size()), 32'd0);
    @(posedge clk); #1 prog_we_req = 1'b0;
    chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
  endtask

  int cyc;
  int w;
  initial begin
    clear_prog();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 32'({prog_ack, ram_en, ram_read_en, ram_write_en, ram_addr, stage_ld,
                           exec_valid, pc, busy, halted, fault}), 32'd0);
    chk("reset_ir", 32'({opcode, addr_mode, operand}), 32'd0);

    // write and start together in IDLE: write granted, start dropped
    @(posedge clk); #1;
    prog_we_req = 1'b1; prog_addr = 8'd5; load_data = 16'h0000; start = 1'b1;
    exp_ack.push_back(8'd5);
    @(posedge clk); #1;
    prog_we_req = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("write_wins_idle", 32'({busy, halted}), 32'd0);

    // basic two-instruction run, fixed timing
    clear_prog();
    model_mem[0] = 16'h0805;
    model_mem[1] = 16'hF800;
    load_prog();
    run_prog(cyc);
    chk("basic_cycles", 32'(cyc), 32'd6);

    // branch to 0xFF, then PC wraps to 0x00
    clear_prog();
    model_mem[0]   = 16'h09FF;
    model_mem[255] = 16'h1233;
    model_mem[1]   = 16'hF800;
    br_tab[0] = 1'b1;
    load_prog();
    run_prog(cyc);

    // timeout with no completion, then completion exactly on the last allowed cycle
    clear_prog();
    model_mem[0] = 16'h0801;
    model_mem[1] = 16'hF800;
    lat_tab[0] = 0;
    load_prog();
    run_prog(cyc);
    lat_tab[0] = EXEC_TIMEOUT;
    run_prog(cyc);

    // random programs with random latencies and branches
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 16'($urandom);
      for (int i = 0; i < MAXI; i++) begin
        w = $urandom_range(0, 19);
        lat_tab[i] = (w < 16) ? w + 1 : (w < 18) ? EXEC_TIMEOUT : 0;
        br_tab[i]  = ($urandom_range(0, 2) == 0);
      end
      lat_tab[MAXI - 1] = 0;
      load_prog();
      run_prog(cyc);
    end

    // reset in the middle of EXEC
    clear_prog();
    model_mem[0] = 16'h0A12;
    lat_tab[0] = 0;
    load_prog();
    begin
      logic [7:0] fpc;
      bit         ffault;
      model(fpc, ffault);
    end
    resp_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!exec_valid && cyc < 20);
    chk("abort_exec_seen", 32'(exec_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_cycle_quiet", 32'({stage_ld, ram_write_en, ram_en, exec_valid}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 32'({prog_ack, ram_en, ram_read_en, ram_write_en, ram_addr, stage_ld,
                           exec_valid, pc, busy, halted, fault}), 32'd0);
    chk("abort_ir", 32'({opcode, addr_mode, operand}), 32'd0);
    chk("abort_queues", 32'(exp_fetch.size() + exp_exec.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
Fetch/decode/execute sequencer for the accumulator CPU. It owns the program counter and the instruction register, and drives the instruction RAM control lines and the stage-register load strobe. It hands each decoded instruction to the datapath and waits for completion. It also arbitrates instruction-RAM access between the external program loader (idle/halted only) and instruction fetch.

Parameters:
ADDR_W, 8, instruction RAM address / PC width
OPC_W, 5, opcode field width
HALT_OPC, 5'h1F, opcode that stops execution
EXEC_TIMEOUT, 16, max EXEC cycles before fault (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin execution at PC=0 (IDLE/HALT only)
prog_we_req  in  1  loader write request
prog_addr  in  ADDR_W  loader write address
prog_ack  out  1  loader write granted this cycle
ram_en  out  1  instruction RAM enable
ram_read_en  out  1  instruction RAM read strobe
ram_write_en  out  1  instruction RAM write strobe
ram_addr  out  ADDR_W  instruction RAM address
ram_rdata  in  16  instruction word {opcode[15:11], mode[10:8], data[7:0]}, 1-cycle sync read
stage_ld  out  1  stage register load strobe
opcode  out  OPC_W  IR opcode
addr_mode  out  3  IR addressing mode
operand  out  8  IR data/address field
exec_valid  out  1  one-cycle pulse: IR ready for datapath
exec_done  in  1  datapath finished current instruction
branch_taken  in  1  qualified by exec_done; next PC = operand
pc  out  ADDR_W  current program counter
busy  out  1  state in FETCH/DECODE/EXEC
halted  out  1  state == HALT
fault  out  1  sticky; set on EXEC timeout, cleared by start or rst

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=0, IR=0, timeout counter=0, fault=0. All outputs 0 in the following cycle. rst mid-operation aborts immediately; no RAM write or stage_ld is issued in the reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE/HALT (load window): prog_ack=ram_write_en=ram_en=prog_we_req and ram_addr=prog_addr, all combinational, same cycle. When prog_we_req=1, start is ignored that cycle (write wins). When prog_we_req=0 and start=1: pc<=0, fault<=0, go to FETCH.
- FETCH (1 cycle): ram_en=ram_read_en=1, ram_addr=pc. Next state DECODE.
- DECODE (1 cycle): IR<=ram_rdata, stage_ld=1, pc<=pc+1 (mod 2^ADDR_W, 8'hFF wraps to 8'h00). If ram_rdata[15:11]==HALT_OPC, go to HALT (no exec_valid); otherwise go to EXEC.
- EXEC: exec_valid=1 in the first EXEC cycle only. The timeout counter counts EXEC cycles.
  - exec_done=1 (may coincide with exec_valid for single-cycle ops): if branch_taken, pc<=operand; go to FETCH.
  - Counter reaching EXEC_TIMEOUT with no exec_done: fault<=1, go to HALT.
  - exec_done on the timeout cycle counts as completion; no fault.
- prog_we_req while busy: prog_ack=0, no RAM write. The loader holds its request until granted.
- start while busy: ignored.
- branch_taken without exec_done: ignored.
- Minimum instruction time is 3 cycles (FETCH, DECODE, 1-cycle EXEC).
- IR fields (opcode/addr_mode/operand) hold their values until the next DECODE, and through HALT.

Test Plan:
1. Program load: after rst, in IDLE drive prog_we_req=1 with prog_addr=0,1,2 on consecutive cycles -> prog_ack=ram_write_en=1 and ram_addr=0,1,2 in the same cycles; busy=0.
2. Basic run: RAM[0]=16'h0805 (op 01), RAM[1]=16'hF800 (HALT). Pulse start at cycle 0, tie exec_done=1 -> c1 FETCH ram_addr=0; c2 stage_ld, pc=1; c3 exec_valid, opcode=01, operand=05; c4 FETCH addr 1; c5 stage_ld; c6 onward halted=1, pc=2, exec_valid never asserted for HALT.
3. Branch and wrap: instruction at addr 0 with operand 8'hFF and branch_taken=1 at exec_done -> next FETCH ram_addr=8'hFF. A non-HALT instruction at 8'hFF -> following FETCH ram_addr=8'h00.
4. Timeout: hold exec_done=0 -> after 16 EXEC cycles fault=1, halted=1. Next start pulse clears fault. A second case with exec_done on cycle 16 -> no fault.
5. Arbitration: prog_we_req=1 during FETCH/EXEC -> prog_ack=0, ram_write_en=0 until HALT; then granted the same cycle. prog_we_req and start together in IDLE -> write granted, state stays IDLE.
6. Reset mid-EXEC with exec_done=0 -> next cycle state IDLE, pc=0, opcode/operand=0, exec_valid/stage_ld/ram_* all 0.
